// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state encoding, default device ID and R/W bit position.
package sccb_pkg;

    localparam logic [7:0]  SCCB_DEFAULT_ID = 8'h42;
    localparam int unsigned SCCB_RW_BIT     = 0;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_DEV       = 4'd1;
    localparam logic [3:0] ST_DEV_ACK   = 4'd2;
    localparam logic [3:0] ST_ADDR      = 4'd3;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RD_NA     = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    function automatic logic [7:0] sccb_read_id(input logic [7:0] id);
        logic [7:0] r;
        r = id;
        r[SCCB_RW_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sccb_responder_if.sv
// Register-side port bundle of the SCCB responder.
interface sccb_responder_if;

    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output busy,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  busy,
        output reg_rdata
    );

endinterface

// File: rtl/sccb_bus_sync.sv
// Two-flop synchronizers for scl/sda plus scl edge and START/STOP detection.
module sccb_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    // Flops reset to 1 so an idle (pulled-up) bus shows no edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    always_comb begin
        sda_in    = sda_s2;
        scl_rise  = scl_s2 & ~scl_d;
        scl_fall  = ~scl_s2 & scl_d;
        start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
        stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    end

endmodule

// File: rtl/sccb_responder.sv
// SCCB register-bus responder. Read path (ID|1, RDATA/RD_NA) only when SCCB_READ_EN is defined.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID = SCCB_DEFAULT_ID
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl,
    inout  wire              sda,
    sccb_responder_if.master regs
);

    logic       sda_in, scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] rx_byte;
    logic       sda_oe;
    logic       wr_seen;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       busy;
`ifdef SCCB_READ_EN
    logic       is_read;
`else
    logic       unused_rdata;
    assign unused_rdata = ^regs.reg_rdata;
`endif

    sccb_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign sda             = sda_oe ? 1'b0 : 1'bz;
    assign regs.reg_addr   = reg_addr;
    assign regs.reg_wdata  = reg_wdata;
    assign regs.reg_we     = reg_we;
    assign regs.busy       = busy;

    always_comb begin
        rx_byte = {shreg[6:0], sda_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            sda_oe    <= 1'b0;
            wr_seen   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
`ifdef SCCB_READ_EN
            is_read   <= 1'b0;
`endif
        end else begin
            reg_we <= 1'b0;
            if (start_det) begin
                state   <= ST_DEV;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_DEV: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (rx_byte == DEVICE_ID) begin
                                    state <= ST_DEV_ACK;
`ifdef SCCB_READ_EN
                                    is_read <= 1'b0;
                                end else if (rx_byte == sccb_read_id(DEVICE_ID)) begin
                                    state   <= ST_DEV_ACK;
                                    is_read <= 1'b1;
`endif
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= ST_ADDR_ACK;
                        end
                    end
                    // Address bumps together with the strobe of every byte after the first,
                    // so a truncated byte leaves reg_addr untouched.
                    ST_WDATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                reg_wdata <= rx_byte;
                                reg_we    <= 1'b1;
                                wr_seen   <= 1'b1;
                                if (wr_seen)
                                    reg_addr <= reg_addr + 8'd1;
                                state <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_DEV_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bit_cnt <= '0;
`ifdef SCCB_READ_EN
                                if (is_read) begin
                                    shreg  <= regs.reg_rdata;
                                    sda_oe <= ~regs.reg_rdata[7];
                                    state  <= ST_RDATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= ST_ADDR;
                                end
`else
                                sda_oe <= 1'b0;
                                state  <= ST_ADDR;
`endif
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe   <= 1'b0;
                                bit_cnt  <= '0;
                                reg_addr <= shreg;
                                wr_seen  <= 1'b0;
                                state    <= ST_WDATA;
                            end
                        end
                    end
                    ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_WDATA;
                            end
                        end
                    end
`ifdef SCCB_READ_EN
                    ST_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                state  <= ST_RD_NA;
                            end else begin
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_oe  <= ~shreg[6];
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_RD_NA: begin
                        if (scl_rise)
                            state <= ST_IGNORE;
                    end
`endif
                    ST_IDLE, ST_IGNORE: begin
                    end
                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder; the read test adapts to SCCB_READ_EN.
module tb_sccb_responder;
    import sccb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        scl_m;
    logic        sda_low;
    wire         sda;
    int unsigned q;
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  we_addr [16];
    logic [7:0]  we_data [16];
    int unsigned we_cnt = 0;
    int unsigned base;
    logic        ack;
    logic        na;
    logic [7:0]  rd;

    sccb_responder_if regs_if ();

    assign regs_if.reg_rdata = 8'hA5;
    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    sccb_responder #(.DEVICE_ID(8'h42)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .scl   (scl_m),
        .sda   (sda),
        .regs  (regs_if)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (regs_if.reg_we) begin
            if (we_cnt < 16) begin
                we_addr[we_cnt] = regs_if.reg_addr;
                we_data[we_cnt] = regs_if.reg_wdata;
            end
            we_cnt = we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        sda_low = 1'b0;
        wait_clk(q);
        scl_m = 1'b1;
        wait_clk(q);
        sda_low = 1'b1;
        wait_clk(q);
        scl_m = 1'b0;
        wait_clk(q);
    endtask

    task automatic bus_stop;
        sda_low = 1'b1;
        wait_clk(q);
        scl_m = 1'b1;
        wait_clk(q);
        sda_low = 1'b0;
        wait_clk(q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_low = ~b[7-i];
            wait_clk(q);
            scl_m = 1'b1;
            wait_clk(2 * q);
            scl_m = 1'b0;
            wait_clk(q);
        end
    endtask

    // Ninth clock: master releases sda and samples the responder's answer
    task automatic ack_slot(output logic a);
        sda_low = 1'b0;
        wait_clk(q);
        scl_m = 1'b1;
        wait_clk(q);
        a = sda;
        wait_clk(q);
        scl_m = 1'b0;
        wait_clk(q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        send_bits(b, 8);
        ack_slot(a);
    endtask

    task automatic read_byte(output logic [7:0] b, output logic na_bit);
        sda_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_clk(q);
            scl_m = 1'b1;
            wait_clk(q);
            b[7-i] = sda;
            wait_clk(q);
            scl_m = 1'b0;
            wait_clk(q);
        end
        ack_slot(na_bit);
    endtask

    initial begin
        rst_n   = 1'b0;
        scl_m   = 1'b1;
        sda_low = 1'b0;
        q       = 125;
        wait_clk(3);
        chk("rst_addr",  32'(regs_if.reg_addr), 32'h00);
        chk("rst_wdata", 32'(regs_if.reg_wdata), 32'h00);
        chk("rst_we",    32'(regs_if.reg_we), 32'h0);
        chk("rst_busy",  32'(regs_if.busy), 32'h0);
        chk("rst_sda",   32'(sda), 32'h1);
        rst_n = 1'b1;
        wait_clk(5);

        // Write 42/12/80 at a 500-clk scl period
        base = we_cnt;
        bus_start();
        chk("t1_busy_on", 32'(regs_if.busy), 32'h1);
        send_byte(8'h42, ack); chk("t1_ack_dev",  32'(ack), 32'h0);
        send_byte(8'h12, ack); chk("t1_ack_addr", 32'(ack), 32'h0);
        send_byte(8'h80, ack); chk("t1_ack_data", 32'(ack), 32'h0);
        bus_stop();
        wait_clk(6);
        chk("t1_busy_off", 32'(regs_if.busy), 32'h0);
        chk("t1_we_cnt",   we_cnt - base, 32'd1);
        chk("t1_we_addr",  32'(we_addr[base]), 32'h12);
        chk("t1_we_data",  32'(we_data[base]), 32'h80);
        chk("t1_state",    32'(dut.state), 32'(ST_IDLE));

        q = 25;

        // Foreign device ID
        base = we_cnt;
        bus_start();
        send_byte(8'h60, ack); chk("t2_noack",  32'(ack), 32'h1);
        chk("t2_state_ign", 32'(dut.state), 32'(ST_IGNORE));
        send_byte(8'h55, ack); chk("t2_noack2", 32'(ack), 32'h1);
        chk("t2_state_ign2", 32'(dut.state), 32'(ST_IGNORE));
        bus_stop();
        wait_clk(6);
        chk("t2_state_idle", 32'(dut.state), 32'(ST_IDLE));
        chk("t2_we_cnt", we_cnt - base, 32'd0);

        // Burst with address wrap
        base = we_cnt;
        bus_start();
        send_byte(8'h42, ack); chk("t3_ack_dev", 32'(ack), 32'h0);
        send_byte(8'hFF, ack); chk("t3_ack_addr", 32'(ack), 32'h0);
        send_byte(8'h11, ack); chk("t3_ack_d0", 32'(ack), 32'h0);
        send_byte(8'h22, ack); chk("t3_ack_d1", 32'(ack), 32'h0);
        bus_stop();
        wait_clk(6);
        chk("t3_we_cnt",   we_cnt - base, 32'd2);
        chk("t3_we0_addr", 32'(we_addr[base]), 32'hFF);
        chk("t3_we0_data", 32'(we_data[base]), 32'h11);
        chk("t3_we1_addr", 32'(we_addr[base+1]), 32'h00);
        chk("t3_we1_data", 32'(we_data[base+1]), 32'h22);

        // Address set 3A, then read frame
        bus_start();
        send_byte(8'h42, ack); chk("t4_ack_dev", 32'(ack), 32'h0);
        send_byte(8'h3A, ack); chk("t4_ack_addr", 32'(ack), 32'h0);
        bus_stop();
        wait_clk(6);
        chk("t4_addr", 32'(regs_if.reg_addr), 32'h3A);
        bus_start();
        send_byte(8'h43, ack);
`ifdef SCCB_READ_EN
        chk("t4_ack_rd", 32'(ack), 32'h0);
        read_byte(rd, na);
        chk("t4_rdata", 32'(rd), 32'hA5);
        chk("t4_na_released", 32'(na), 32'h1);
        chk("t4_state_ign", 32'(dut.state), 32'(ST_IGNORE));
`else
        chk("t4_noack_rd", 32'(ack), 32'h1);
        chk("t4_state_ign", 32'(dut.state), 32'(ST_IGNORE));
`endif
        bus_stop();
        wait_clk(6);
        chk("t4_busy_off", 32'(regs_if.busy), 32'h0);

        // STOP after four data bits, then a normal write
        base = we_cnt;
        bus_start();
        send_byte(8'h42, ack); chk("t5_ack_dev", 32'(ack), 32'h0);
        send_byte(8'h01, ack); chk("t5_ack_addr", 32'(ack), 32'h0);
        send_bits(8'hC3, 4);
        bus_stop();
        wait_clk(6);
        chk("t5_trunc_we",    we_cnt - base, 32'd0);
        chk("t5_trunc_state", 32'(dut.state), 32'(ST_IDLE));
        chk("t5_trunc_busy",  32'(regs_if.busy), 32'h0);
        bus_start();
        send_byte(8'h42, ack); chk("t5b_ack_dev", 32'(ack), 32'h0);
        send_byte(8'h01, ack); chk("t5b_ack_addr", 32'(ack), 32'h0);
        send_byte(8'h07, ack); chk("t5b_ack_data", 32'(ack), 32'h0);
        bus_stop();
        wait_clk(6);
        chk("t5b_we_cnt",  we_cnt - base, 32'd1);
        chk("t5b_we_addr", 32'(we_addr[base]), 32'h01);
        chk("t5b_we_data", 32'(we_data[base]), 32'h07);

        // Reset during the address byte, asserted between clock edges
        base = we_cnt;
        bus_start();
        send_byte(8'h42, ack); chk("t6_ack_dev", 32'(ack), 32'h0);
        send_bits(8'h5C, 3);
        sda_low = 1'b0;
        wait_clk(2);
        #5 rst_n = 1'b0;
        #1;
        chk("t6_addr",  32'(regs_if.reg_addr), 32'h00);
        chk("t6_wdata", 32'(regs_if.reg_wdata), 32'h00);
        chk("t6_we",    32'(regs_if.reg_we), 32'h0);
        chk("t6_busy",  32'(regs_if.busy), 32'h0);
        chk("t6_sda",   32'(sda), 32'h1);
        chk("t6_state", 32'(dut.state), 32'(ST_IDLE));
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        send_bits(8'hA0, 5);
        ack_slot(ack);
        chk("t6_noack_after", 32'(ack), 32'h1);
        bus_stop();
        wait_clk(6);
        chk("t6_we_cnt",   we_cnt - base, 32'd0);
        chk("t6_busy_end", 32'(regs_if.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
